// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive sampling path.
package uart_rx_pkg;

    localparam int unsigned EDGE_W = 6;
    localparam int unsigned BIT_W  = 4;

    localparam logic [EDGE_W-1:0] PRESCALE_8  = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] PRESCALE_16 = EDGE_W'(16);
    localparam logic [EDGE_W-1:0] PRESCALE_32 = EDGE_W'(32);

    localparam logic [BIT_W-1:0] BIT_CNT_MAX = BIT_W'(15);

    // Unsupported oversampling ratios fall back to 8.
    function automatic logic [EDGE_W-1:0] eff_ratio(input logic [EDGE_W-1:0] p);
        logic [EDGE_W-1:0] r;
        r = PRESCALE_8;
        case (p)
            PRESCALE_8:  r = PRESCALE_8;
            PRESCALE_16: r = PRESCALE_16;
            PRESCALE_32: r = PRESCALE_32;
            default:     r = PRESCALE_8;
        endcase
        return r;
    endfunction

    // Two-out-of-three vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the idle-high serial line.
module uart_rx_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Both stages reset to the idle level so no false start bit appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling counters and three-point majority sampler.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_in,
    input  logic [EDGE_W-1:0] prescale,
    input  logic              enable,
    input  logic              reset_bit_cnt,
    input  logic              dat_samp_en,
    output logic              rx_sync,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sampled_bit,
    output logic              sample_valid
);

    logic [EDGE_W-1:0] prescale_q;
    logic [EDGE_W-1:0] ratio;
    logic [EDGE_W-1:0] half;
    logic [EDGE_W-1:0] last_edge;
    logic              count_clr;
    logic              edge_wrap;
    logic              samp_en;
    logic              at_s0;
    logic              at_s1;
    logic              at_s2;
    logic              s0;
    logic              s1;
    logic              s2;
    logic              s2_next;
    logic              got0;
    logic              got1;

    uart_rx_sync_2ff u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (RX_in),
        .dout (rx_sync)
    );

    // Decode ratio, sample points and control qualifiers.
    always_comb begin
        ratio     = eff_ratio(prescale_q);
        half      = ratio >> 1;
        last_edge = ratio - EDGE_W'(1);
        count_clr = reset_bit_cnt | ~enable;
        edge_wrap = (edge_cnt == last_edge);
        samp_en   = enable & dat_samp_en;
        at_s0     = (edge_cnt == (half - EDGE_W'(1)));
        at_s1     = (edge_cnt == half);
        at_s2     = (edge_cnt == (half + EDGE_W'(1)));
        s2_next   = (samp_en && at_s2) ? rx_sync : s2;
    end

    // Prescale is latched only while idle so a frame keeps one bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= PRESCALE_8;
        end else if (!enable) begin
            prescale_q <= prescale;
        end
    end

    // Edge counter wraps every bit; bit counter saturates at its maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (count_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_wrap) begin
            edge_cnt <= '0;
            if (bit_cnt != BIT_CNT_MAX) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end

    // Capture three mid-bit samples and publish the vote once all three landed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            s2           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (samp_en) begin
                if (at_s0) begin
                    s0 <= rx_sync;
                end
                if (at_s1) begin
                    s1 <= rx_sync;
                end
                if (at_s2) begin
                    s2 <= rx_sync;
                    if (got1) begin
                        sampled_bit  <= majority3(s0, s1, s2_next);
                        sample_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // Track whether the earlier captures of the current bit actually happened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got0 <= 1'b0;
            got1 <= 1'b0;
        end else if (count_clr) begin
            got0 <= 1'b0;
            got1 <= 1'b0;
        end else begin
            if (at_s0) begin
                got0 <= samp_en;
            end
            if (at_s1) begin
                got1 <= samp_en & got0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed vectors plus randomized run vs a reference model.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       enable = 1'b0;
    logic       reset_bit_cnt = 1'b0;
    logic       dat_samp_en = 1'b0;
    logic       rx_sync;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;

    uart_rx_sampler dut (
        .clk           (clk),
        .rst           (rst),
        .RX_in         (RX_in),
        .prescale      (prescale),
        .enable        (enable),
        .reset_bit_cnt (reset_bit_cnt),
        .dat_samp_en   (dat_samp_en),
        .rx_sync       (rx_sync),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .sampled_bit   (sampled_bit),
        .sample_valid  (sample_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: k counts enabled clocks since the last clear,
    // so the edge index is k mod ratio and the bit index is k div ratio.
    int m_k;
    int m_ep = 0;
    int m_pq;
    bit m_d1, m_sync, m_sb, m_sv;
    bit cap_v [3];
    int cap_ep [3];
    int cap_bid [3];

    function automatic int eff(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_k  = 0;
        m_ep = m_ep + 1;
        m_pq = 8;
        m_d1 = 1'b1;
        m_sync = 1'b1;
        m_sb = 1'b1;
        m_sv = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cap_v[j] = 1'b1;
            cap_ep[j] = -1;
            cap_bid[j] = -1;
        end
    endtask

    task automatic model_clock();
        int r, h, e, b;
        bit os;
        os = m_sync;
        r = eff(m_pq);
        h = r / 2;
        e = m_k % r;
        b = m_k / r;
        m_sv = 1'b0;
        if (enable && dat_samp_en) begin
            for (int j = 0; j < 2; j++) begin
                if (e == h - 1 + j) begin
                    cap_v[j] = os;
                    cap_ep[j] = m_ep;
                    cap_bid[j] = b;
                end
            end
            if (e == h + 1 && cap_ep[0] == m_ep && cap_bid[0] == b
                && cap_ep[1] == m_ep && cap_bid[1] == b) begin
                m_sb = ((int'(cap_v[0]) + int'(cap_v[1]) + int'(os)) >= 2);
                m_sv = 1'b1;
            end
        end
        if (reset_bit_cnt || !enable) begin
            m_k = 0;
            m_ep = m_ep + 1;
        end else begin
            m_k = m_k + 1;
        end
        if (!enable) m_pq = int'(prescale);
        m_sync = m_d1;
        m_d1 = RX_in;
    endtask

    task automatic check_all();
        int r, eb;
        r = eff(m_pq);
        eb = m_k / r;
        if (eb > 15) eb = 15;
        check("rx_sync", int'(rx_sync), int'(m_sync));
        check("edge_cnt", int'(edge_cnt), m_k % r);
        check("bit_cnt", int'(bit_cnt), eb);
        check("sampled_bit", int'(sampled_bit), int'(m_sb));
        check("sample_valid", int'(sample_valid), int'(m_sv));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_clock();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Send nbits (LSB first) aligned so edge 0 of each bit sees that bit on rx_sync.
    task automatic send_bits(input int pre, input int nbits, input logic [15:0] bits,
                             input int glitch_step, output logic [15:0] got,
                             output int ngot, output int bad_edge);
        got = '0;
        ngot = 0;
        bad_edge = 0;
        enable = 1'b0;
        prescale = 6'(pre);
        RX_in = 1'b1;
        dat_samp_en = 1'b1;
        step_n(3);
        for (int i = 0; i < nbits * pre + 2; i++) begin
            RX_in = (i >= nbits * pre) ? 1'b1 : bits[i / pre];
            if (i == glitch_step) RX_in = 1'b0;
            enable = (i >= 2);
            step();
            if (sample_valid) begin
                if (ngot < 16) got[ngot] = sampled_bit;
                ngot++;
                if (int'(edge_cnt) != pre / 2 + 2) bad_edge++;
            end
        end
        enable = 1'b0;
        RX_in = 1'b1;
        step();
    endtask

    typedef struct {
        int pre;
        int n;
        int exp_edge;
        int exp_bit;
    } vec_t;

    vec_t vt [11];
    int   exp_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   pre_pick [5] = '{8, 16, 32, 20, 0};

    initial begin
        logic [15:0] got;
        int ngot, bad_edge, maxe;

        vt[0]  = '{8, 5, 5, 0};
        vt[1]  = '{8, 8, 0, 1};
        vt[2]  = '{8, 13, 5, 1};
        vt[3]  = '{16, 15, 15, 0};
        vt[4]  = '{16, 16, 0, 1};
        vt[5]  = '{32, 31, 31, 0};
        vt[6]  = '{32, 33, 1, 1};
        vt[7]  = '{20, 9, 1, 1};
        vt[8]  = '{0, 7, 7, 0};
        vt[9]  = '{8, 200, 0, 15};
        vt[10] = '{16, 255, 15, 15};

        // Reset state
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("reset_rx_sync", int'(rx_sync), 1);
        check("reset_edge_cnt", int'(edge_cnt), 0);
        check("reset_bit_cnt", int'(bit_cnt), 0);
        check("reset_sampled_bit", int'(sampled_bit), 1);
        check("reset_sample_valid", int'(sample_valid), 0);
        step_n(2);
        rst = 1'b1;
        step_n(2);

        // Counter vectors: clocks enabled from a clear -> expected edge/bit
        for (int v = 0; v < 11; v++) begin
            enable = 1'b0;
            reset_bit_cnt = 1'b0;
            prescale = 6'(vt[v].pre);
            step();
            enable = 1'b1;
            step_n(vt[v].n);
            check($sformatf("vec%0d_edge", v), int'(edge_cnt), vt[v].exp_edge);
            check($sformatf("vec%0d_bit", v), int'(bit_cnt), vt[v].exp_bit);
        end
        enable = 1'b0;
        step();

        // 8N1 frame 0xA5 at ratio 8
        send_bits(8, 10, {6'b0, 1'b1, 8'hA5, 1'b0}, -1, got, ngot, bad_edge);
        check("frame_count", ngot, 10);
        check("frame_valid_edge", bad_edge, 0);
        for (int j = 0; j < 10; j++) check($sformatf("frame_bit%0d", j), int'(got[j]), exp_seq[j]);

        // Single-clock low glitch at edge 8 of a '1' bit at ratio 16
        send_bits(16, 2, 16'b10, 24, got, ngot, bad_edge);
        check("glitch_count", ngot, 2);
        check("glitch_bit0", int'(got[0]), 0);
        check("glitch_bit1", int'(got[1]), 1);

        // Bit counter saturation over 33 bit periods
        prescale = 6'd8;
        step();
        enable = 1'b1;
        step_n(264);
        check("sat_bit", int'(bit_cnt), 15);
        check("sat_edge", int'(edge_cnt), 0);
        maxe = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (int'(edge_cnt) > maxe) maxe = int'(edge_cnt);
        end
        check("sat_edge_max", maxe, 7);
        check("sat_bit_hold", int'(bit_cnt), 15);

        // reset_bit_cnt beats enable at edge 5
        enable = 1'b0;
        step();
        enable = 1'b1;
        step_n(13);
        check("clr_pre_edge", int'(edge_cnt), 5);
        reset_bit_cnt = 1'b1;
        step();
        reset_bit_cnt = 1'b0;
        check("clr_edge", int'(edge_cnt), 0);
        check("clr_bit", int'(bit_cnt), 0);

        // Prescale change while enabled is ignored until enable drops
        enable = 1'b0;
        prescale = 6'd16;
        step();
        enable = 1'b1;
        step_n(20);
        prescale = 6'd32;
        maxe = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (int'(edge_cnt) > maxe) maxe = int'(edge_cnt);
        end
        check("frozen_edge_max", maxe, 15);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step_n(31);
        check("relatch_edge", int'(edge_cnt), 31);

        // Asynchronous reset at bit 4, edge 3
        enable = 1'b0;
        prescale = 6'd8;
        dat_samp_en = 1'b1;
        step();
        enable = 1'b1;
        step_n(35);
        check("prerst_edge", int'(edge_cnt), 3);
        check("prerst_bit", int'(bit_cnt), 4);
        rst = 1'b0;
        #1;
        check("arst_rx_sync", int'(rx_sync), 1);
        check("arst_edge", int'(edge_cnt), 0);
        check("arst_bit", int'(bit_cnt), 0);
        check("arst_sampled", int'(sampled_bit), 1);
        check("arst_valid", int'(sample_valid), 0);
        model_reset();
        step_n(3);
        rst = 1'b1;
        step_n(12);
        enable = 1'b0;
        step();

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if (enable) begin
                if ($urandom_range(0, 59) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) enable = 1'b1;
            end
            reset_bit_cnt = ($urandom_range(0, 49) == 0);
            dat_samp_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) RX_in = ~RX_in;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 5) == 0) prescale = 6'($urandom_range(0, 63));
                else prescale = 6'(pre_pick[$urandom_range(0, 4)]);
            end
            if ($urandom_range(0, 999) == 0) rst = 1'b0;
            else rst = 1'b1;
            step();
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
